// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_if
//  Description : Handshake bundle between the divide controller and the
//                iterative 32-bit divider (start/cancel/operands/result).
//  Revision    : 1.0  initial release
// ============================================================================
interface div_ctrl_if;
    logic        div_start;     // one-cycle start pulse
    logic        div_signed;    // 1 = signed divide
    logic [31:0] div_x;         // dividend
    logic [31:0] div_y;         // divisor
    logic        div_cancel;    // abort the running divide
    logic [31:0] div_s;         // quotient
    logic [31:0] div_r;         // remainder
    logic        div_complete;  // result valid for one cycle

    // Controller side
    modport master (
        output div_start,
        output div_signed,
        output div_x,
        output div_y,
        output div_cancel,
        input  div_s,
        input  div_r,
        input  div_complete
    );

    // Divider side
    modport slave (
        input  div_start,
        input  div_signed,
        input  div_x,
        input  div_y,
        input  div_cancel,
        output div_s,
        output div_r,
        output div_complete
    );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Sequences the iterative divider for DIV/DIVU, owns HI/LO,
//                services MTHI/MTLO/MFHI/MFLO, stalls the pipe while a divide
//                is outstanding, cancels on flush and flags a hung divider.
//  Revision    : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int TIMEOUT = 15          // BUSY cycles allowed before giving up
) (
    input  logic        div_clk,
    input  logic        resetn,
    // EX request
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        req_ready,
    input  logic        flush,
    // HI/LO moves
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    output logic        mt_stall,
    output logic        mf_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    // status
    output logic        busy,
    output logic        timeout_err,
    // divider
    div_ctrl_if.master  dv
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_BUSY    = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Event decode shared by the FSM and the datapath. Flush dominates
    // everything; a completion in the timeout cycle still counts as success.
    logic w_idle;
    logic w_accept;
    logic w_done;
    logic w_tmo;

    assign w_idle   = (state_q == ST_IDLE);
    assign w_accept = w_idle && req_valid && !flush;
    assign w_done   = !w_idle && !flush && dv.div_complete;
    assign w_tmo    = !w_idle && !flush && !dv.div_complete && (cnt_q >= CNT_LAST);

    // State register
    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush || w_done || w_tmo) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: request handshake, divider drive, pipeline stalls
    always_comb begin
        req_ready     = w_idle;
        busy          = !w_idle;
        dv.div_start  = w_accept;
        dv.div_signed = w_accept ? req_signed : 1'b0;
        dv.div_x      = w_accept ? req_x      : 32'd0;
        dv.div_y      = w_accept ? req_y      : 32'd0;
        dv.div_cancel = !w_idle && (flush || w_tmo);
        mt_stall      = !w_idle && (mthi_we || mtlo_we);
        mf_stall      = !w_idle && mf_req;
    end

    // HI/LO, busy-cycle counter and sticky timeout flag: next values
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        err_d = err_q;

        if (w_idle) begin
            // MT writes land even when a divide is accepted in the same cycle;
            // the divide result overwrites them later.
            if (!flush && mthi_we) begin
                hi_d = mt_data;
            end
            if (!flush && mtlo_we) begin
                lo_d = mt_data;
            end
            if (w_accept) begin
                cnt_d = '0;
            end
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (w_done) begin
                lo_d = dv.div_s;
                hi_d = dv.div_r;
            end
            if (w_tmo) begin
                err_d = 1'b1;
            end
        end
    end

    // HI/LO, counter and error flag registers
    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign timeout_err = err_q;

endmodule
`default_nettype wire
